// File: rtl/seq_mult.sv
// seq_mult -- iterative shift-add multiplier, N x N -> 2N product.
//
// One add per clock: operands are reduced to magnitudes on accept, the
// magnitude product is accumulated over N CALC steps, and the sign is
// applied in a single SIGN step.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   start        request a multiply (sampled only in IDLE)
//   signed_mode  1 = two's complement operands/product, 0 = unsigned
//   a, b         multiplicand / multiplier, sampled with start
//   busy         high while CALC or SIGN is in progress
//   done         one-cycle pulse, product valid from this cycle
//   product      2N-bit result, held until the next completion
//
// Optional build macro:
//   SEQ_MULT_EARLY_TERM_EN  leave CALC as soon as the shifted multiplier is
//                           zero (at least one CALC step is always taken).
module seq_mult #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  localparam logic [N-1:0]   OP_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ACC_ONE = {{(2*N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic           neg;

  logic [N-1:0]   absA;
  logic [N-1:0]   absB;
  logic           lastStep;

  // -2^(N-1) negates to itself, which is the right unsigned magnitude.
  assign absA = (signed_mode && a[N-1]) ? (~a + OP_ONE) : a;
  assign absB = (signed_mode && b[N-1]) ? (~b + OP_ONE) : b;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop once no multiplier bits remain after this step's shift.
  assign lastStep = (count == CW'(N-1)) || (mplier[N-1:1] == '0);
`else
  assign lastStep = (count == CW'(N-1));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, absA};
            mplier <= absB;
            neg    <= signed_mode & (a[N-1] ^ b[N-1]);
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (lastStep) state <= SIGN;
        end
        SIGN: begin
          // A zero magnitude stays zero after negation, so neg needs no guard.
          product <= neg ? (~acc + ACC_ONE) : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got 0x%0h exp 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: plain integer multiplication, truncated to 2N bits.
  function automatic logic [15:0] refProd(input logic [7:0] ra, input logic [7:0] rb, input logic sm);
    int x, y, p;
    if (sm) begin
      x = int'($signed(ra));
      y = int'($signed(rb));
    end else begin
      x = int'(ra);
      y = int'(rb);
    end
    p = x * y;
    return p[15:0];
  endfunction

  // Reference latency in cycles from the accept edge to the done cycle.
  function automatic int refLat(input logic [7:0] rb, input logic sm);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int mag, hb;
    mag = (sm && rb[7]) ? 256 - int'(rb) : int'(rb);
    hb = 0;
    for (int i = 0; i < 8; i++) if (mag[i]) hb = i;
    return hb + 3;
`else
    return N + 2;
`endif
  endfunction

  // One complete operation with start pulsed for one cycle.
  task automatic runOp(input logic [7:0] ta, input logic [7:0] tb, input logic tsm, input string tag);
    int k, busyCyc, lat;
    logic [15:0] expP;
    expP = refProd(ta, tb, tsm);
    lat  = refLat(tb, tsm);
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb; signed_mode = tsm;
    @(posedge clk); #1;  // accept edge E0
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    busyCyc = 0; k = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busyCyc++;
      @(posedge clk); #1;
      if (done) begin k = i; break; end
    end
    chk({tag, "_lat"}, 32'(k + 1), 32'(lat));
    chk({tag, "_prod"}, 32'(product), 32'(expP));
    chk({tag, "_busycyc"}, 32'(busyCyc), 32'(lat - 1));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(product), 32'(expP));
  endtask

  task automatic waitDone(output int edges);
    edges = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin edges = i; break; end
    end
  endtask

  initial begin
    int k, pulses, doneEdge, sp;
    logic [15:0] pAt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    @(negedge clk); resetn = 1'b1;

    // Directed operand patterns
    runOp(8'hFF, 8'hFF, 1'b0, "ffxff_u");
    runOp(8'h80, 8'h80, 1'b1, "80x80_s");
    runOp(8'hFD, 8'h05, 1'b1, "fdx05_s");
    runOp(8'hFD, 8'h05, 1'b0, "fdx05_u");
    runOp(8'h7B, 8'h01, 1'b0, "7bx01_u");
    runOp(8'h7B, 8'h00, 1'b0, "7bx00_u");
    runOp(8'h00, 8'hFB, 1'b1, "00xfb_s");
    runOp(8'h7F, 8'h80, 1'b1, "7fx80_s");

    // start pulsed mid-CALC must be ignored
    @(posedge clk); #1;
    start = 1'b1; a = 8'h11; b = 8'h0F; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; start = 1'b1; a = 8'h02; b = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; doneEdge = 0; pAt = '0;
    for (int i = 4; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (pulses == 1) begin doneEdge = i; pAt = product; end
      end
    end
    chk("midstart_pulses", 32'(pulses), 32'd1);
    chk("midstart_lat", 32'(doneEdge + 1), 32'(refLat(8'h0F, 1'b0)));
    chk("midstart_prod", 32'(pAt), 32'(refProd(8'h11, 8'h0F, 1'b0)));
    chk("midstart_hold", 32'(product), 32'(refProd(8'h11, 8'h0F, 1'b0)));

    // start held high: back-to-back (3,4), (5,6), (7,8)
    @(posedge clk); #1;
    start = 1'b1; a = 8'd3; b = 8'd4; signed_mode = 1'b0;
    @(posedge clk); #1;
    a = 8'd5; b = 8'd6;
    waitDone(k);
    chk("b2b0_lat", 32'(k + 1), 32'(refLat(8'd4, 1'b0)));
    chk("b2b0_prod", 32'(product), 32'd12);
    @(posedge clk); #1;  // next accept in the done cycle
    chk("b2b1_oldhold", 32'(product), 32'd12);
    a = 8'd7; b = 8'd8;
    waitDone(k);
    sp = (k < 0) ? -1 : k + 1;
    chk("b2b1_spacing", 32'(sp), 32'(refLat(8'd6, 1'b0)));
    chk("b2b1_prod", 32'(product), 32'd30);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(k);
    sp = (k < 0) ? -1 : k + 1;
    chk("b2b2_spacing", 32'(sp), 32'(refLat(8'd8, 1'b0)));
    chk("b2b2_prod", 32'(product), 32'd56);
    @(posedge clk); #1;
    chk("b2b2_nomore", 32'(busy), 32'd0);

    // Asynchronous reset during CALC
    @(posedge clk); #1;
    start = 1'b1; a = 8'hAB; b = 8'hFF; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_prod", 32'(product), 32'd0);
    @(negedge clk); resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("arst_quiet", 32'(pulses), 32'd0);
    runOp(8'h0C, 8'h0D, 1'b0, "post_rst");

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      runOp(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
